// File: rtl/pwm_carrier_ctrl.sv
// Triangular-carrier PWM scheduler for the PID output stage.
// Builds a symmetric carrier from a programmable half-period and compares it
// with a double-buffered signed duty command. The duty is applied only at the
// carrier valley. Drives a complementary gate pair with dead-time and a
// latched fault shutdown.
module pwm_carrier_ctrl #(
    parameter int unsigned P_DEFAULT  = 2500,
    parameter int unsigned DT_DEFAULT = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [15:0]        cfg_period,
    input  logic [7:0]         cfg_deadtime,
    input  logic               duty_valid,
    output logic               duty_ready,
    input  logic signed [31:0] duty,
    input  logic               fault,
    output logic signed [31:0] carrier,
    output logic               sync_valley,
    output logic               pwm_h,
    output logic               pwm_l,
    output logic [1:0]         state
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Half-period limited to [2, 32767] so the carrier stays well inside 32 bits.
    function automatic logic [15:0] sat_period(input logic [15:0] p);
        if (p < 16'd2)              return 16'd2;
        else if (p > 16'd32767)     return 16'd32767;
        else                        return p;
    endfunction

    // Narrow the 33-bit carrier arithmetic to 32 bits, saturating on overflow.
    function automatic logic signed [DATA_W-1:0] sat33(input logic signed [DATA_W:0] w);
        if (w[DATA_W] == w[DATA_W-1]) return w[DATA_W-1:0];
        else if (w[DATA_W])           return {1'b1, {(DATA_W-1){1'b0}}};
        else                          return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    // Limit a duty command to the carrier span -P..+P.
    function automatic logic signed [DATA_W-1:0] clamp_duty(input logic signed [DATA_W-1:0] d,
                                                            input logic [15:0] p);
        logic signed [DATA_W-1:0] lim;
        lim = $signed({16'd0, p});
        if (d > lim)        return lim;
        else if (d < -lim)  return -lim;
        else                return d;
    endfunction

    state_t                    state_q, state_d;
    logic [15:0]               period_q, period_d;
    logic [7:0]                dt_q, dt_d;
    logic [15:0]               cnt_q, cnt_d;
    logic                      dir_up_q, dir_up_d;
    logic signed [DATA_W-1:0]  carrier_q, carrier_d;
    logic                      valley_q, valley_d;
    logic signed [DATA_W-1:0]  active_q, active_d;
    logic signed [DATA_W-1:0]  pend_q, pend_d;
    logic                      full_q, full_d;
    logic                      raw_q, raw_d;
    logic [7:0]                dtc_q, dtc_d;
    logic                      pwm_h_q, pwm_h_d;
    logic                      pwm_l_q, pwm_l_d;

    logic                      running;
    logic                      raw;
    logic                      fault_entry;
    logic signed [DATA_W:0]    car_wide;

    assign running     = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign fault_entry = (state_d == ST_FAULT) && (state_q != ST_FAULT);
    assign car_wide    = $signed({16'd0, cnt_q, 1'b0}) - $signed({17'd0, period_q});
    assign raw         = (state_q == ST_RUN) && (carrier_q < active_q);

    // Run/fault sequencing; fault overrides every other request.
    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE:  if (enable)  state_d = ST_RUN;
                ST_RUN:   if (!enable) state_d = ST_IDLE;
                ST_FAULT: if (!enable) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Configuration is only taken while idle.
    always_comb begin
        period_d = period_q;
        dt_d     = dt_q;
        if (cfg_valid && (state_q == ST_IDLE)) begin
            period_d = sat_period(cfg_period);
            dt_d     = cfg_deadtime;
        end
    end

    // Up/down counter and registered carrier; both park at zero outside RUN.
    always_comb begin
        cnt_d     = 16'd0;
        dir_up_d  = 1'b1;
        carrier_d = '0;
        valley_d  = 1'b0;
        if (running) begin
            carrier_d = sat33(car_wide);
            valley_d  = (cnt_q == 16'd0);
            if (dir_up_q) begin
                cnt_d    = cnt_q + 16'd1;
                dir_up_d = ((cnt_q + 16'd1) != period_q);
            end else begin
                cnt_d    = cnt_q - 16'd1;
                dir_up_d = (cnt_q == 16'd1);
            end
        end
    end

    // Duty double buffer: pending slot promoted to active only at the valley.
    always_comb begin
        active_d = active_q;
        pend_d   = pend_q;
        full_d   = full_q;
        if (fault_entry) begin
            active_d = '0;
            pend_d   = '0;
            full_d   = 1'b0;
        end else begin
            if (valley_q && full_q) begin
                active_d = clamp_duty(pend_q, period_q);
                full_d   = 1'b0;
            end
            if (duty_valid && !full_q) begin
                pend_d = duty;
                full_d = 1'b1;
            end
        end
    end

    // Dead-time insertion: any raw edge drops both gates, then turns on the
    // gate matching the new raw level after DT cycles.
    always_comb begin
        pwm_h_d = pwm_h_q;
        pwm_l_d = pwm_l_q;
        raw_d   = raw_q;
        dtc_d   = dtc_q;
        if (state_d != ST_RUN) begin
            pwm_h_d = 1'b0;
            pwm_l_d = 1'b0;
            raw_d   = 1'b0;
            dtc_d   = 8'd0;
        end else if (raw != raw_q) begin
            raw_d = raw;
            dtc_d = dt_q;
            if (dt_q == 8'd0) begin
                pwm_h_d = raw;
                pwm_l_d = !raw;
            end else begin
                pwm_h_d = 1'b0;
                pwm_l_d = 1'b0;
            end
        end else if (dtc_q != 8'd0) begin
            dtc_d = dtc_q - 8'd1;
            if (dtc_q == 8'd1) begin
                pwm_h_d = raw_q;
                pwm_l_d = !raw_q;
            end
        end else begin
            pwm_h_d = raw_q;
            pwm_l_d = !raw_q;
        end
    end

    // Register bank for all state above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            period_q  <= 16'(P_DEFAULT);
            dt_q      <= 8'(DT_DEFAULT);
            cnt_q     <= 16'd0;
            dir_up_q  <= 1'b1;
            carrier_q <= '0;
            valley_q  <= 1'b0;
            active_q  <= '0;
            pend_q    <= '0;
            full_q    <= 1'b0;
            raw_q     <= 1'b0;
            dtc_q     <= 8'd0;
            pwm_h_q   <= 1'b0;
            pwm_l_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            dt_q      <= dt_d;
            cnt_q     <= cnt_d;
            dir_up_q  <= dir_up_d;
            carrier_q <= carrier_d;
            valley_q  <= valley_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            full_q    <= full_d;
            raw_q     <= raw_d;
            dtc_q     <= dtc_d;
            pwm_h_q   <= pwm_h_d;
            pwm_l_q   <= pwm_l_d;
        end
    end

    assign cfg_ready   = (state_q == ST_IDLE);
    assign duty_ready  = !full_q;
    assign carrier     = carrier_q;
    assign sync_valley = valley_q;
    assign pwm_h       = pwm_h_q;
    assign pwm_l       = pwm_l_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pwm_carrier_ctrl.sv
// Bench for pwm_carrier_ctrl: carrier shape, duty levels, dead-time,
// double buffering, fault latch and asynchronous reset.
module tb_pwm_carrier_ctrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [15:0]        cfg_period;
    logic [7:0]         cfg_deadtime;
    logic               duty_valid;
    logic               duty_ready;
    logic signed [31:0] duty;
    logic               fault;
    logic signed [31:0] carrier;
    logic               sync_valley;
    logic               pwm_h;
    logic               pwm_l;
    logic [1:0]         state;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int exp_q[$];
    int hq[$];
    int lq[$];

    always #5 clk = ~clk;

    pwm_carrier_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_deadtime(cfg_deadtime),
        .duty_valid(duty_valid), .duty_ready(duty_ready), .duty(duty),
        .fault(fault), .carrier(carrier), .sync_valley(sync_valley),
        .pwm_h(pwm_h), .pwm_l(pwm_l), .state(state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic configure(input int p, input int dt);
        cfg_valid    = 1'b1;
        cfg_period   = 16'(p);
        cfg_deadtime = 8'(dt);
        tick();
        cfg_valid    = 1'b0;
    endtask

    task automatic wait_sync(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (sync_valley === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Expected carrier for sample k after the first valley, half-period p.
    function automatic int model_carrier(input int k, input int p);
        int ph, c;
        ph = k % (2 * p);
        c  = (ph <= p) ? ph : (2 * p - ph);
        return 2 * c - p;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_period = '0;
        cfg_deadtime = '0; duty_valid = 1'b0; duty = '0; fault = 1'b0;
        #17;
        total++; if (state !== 2'd0)      $display("FAIL rst_state got %0d want 0", state);      else passed++;
        total++; if (carrier !== 32'sd0)  $display("FAIL rst_carrier got %0d want 0", carrier);  else passed++;
        total++; if (sync_valley !== 1'b0) $display("FAIL rst_sync got %0b want 0", sync_valley); else passed++;
        total++; if ({pwm_h, pwm_l} !== 2'b00) $display("FAIL rst_pwm got %b want 00", {pwm_h, pwm_l}); else passed++;
        total++; if ({cfg_ready, duty_ready} !== 2'b11) $display("FAIL rst_ready got %b want 11", {cfg_ready, duty_ready}); else passed++;
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_carrier();
        int e;
        configure(4, 0);
        for (int k = 0; k < 16; k++) exp_q.push_back(model_carrier(k, 4));
        enable = 1'b1;
        tick();
        total++; if (state !== 2'd1) $display("FAIL run_entry_state got %0d want 1", state); else passed++;
        total++; if (carrier !== 32'sd0) $display("FAIL run_entry_carrier got %0d want 0", carrier); else passed++;
        for (int k = 0; k < 16; k++) begin
            tick();
            e = exp_q.pop_front();
            total++; if (carrier !== e) $display("FAIL carrier_seq[%0d] got %0d want %0d", k, carrier, e); else passed++;
            total++; if (sync_valley !== (e == -4)) $display("FAIL sync_seq[%0d] got %0b want %0b", k, sync_valley, (e == -4)); else passed++;
        end
    endtask

    task automatic test_duty_levels();
        int duties[3] = '{0, -4, 100};
        int highs[3]  = '{3, 0, 7};
        int h, bad, e;
        bit found;
        for (int t = 0; t < 3; t++) begin
            duty = duties[t];
            duty_valid = 1'b1;
            exp_q.push_back(highs[t]);
            tick();
            duty_valid = 1'b0;
            wait_sync(40, found);
            total++; if (found !== 1'b1) $display("FAIL lvl_sync1[%0d] got timeout want valley", t); else passed++;
            wait_sync(40, found);
            total++; if (found !== 1'b1) $display("FAIL lvl_sync2[%0d] got timeout want valley", t); else passed++;
            h = 0; bad = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (pwm_h === 1'b1) h++;
                if (pwm_l !== ~pwm_h) bad++;
            end
            e = exp_q.pop_front();
            total++; if (h !== e) $display("FAIL duty_high[%0d] got %0d want %0d", duties[t], h, e); else passed++;
            total++; if (bad !== 0) $display("FAIL complement[%0d] got %0d bad want 0", duties[t], bad); else passed++;
        end
    endtask

    task automatic test_deadtime();
        logic ph, pl;
        int both, matched, e;
        enable = 1'b0;
        tick();
        configure(100, 5);
        duty = 0; duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
        enable = 1'b1;
        ph = pwm_h; pl = pwm_l; both = 0; matched = 0;
        for (int k = 0; k < 700; k++) begin
            tick();
            if (pwm_h === 1'b1 && pwm_l === 1'b1) both++;
            if (pl === 1'b1 && pwm_l === 1'b0) hq.push_back(cyc + 5);
            if (ph === 1'b1 && pwm_h === 1'b0) lq.push_back(cyc + 5);
            if (ph === 1'b0 && pwm_h === 1'b1 && hq.size() > 0) begin
                e = hq.pop_front(); matched++;
                total++; if (cyc !== e) $display("FAIL dt_h_rise got cyc %0d want %0d", cyc, e); else passed++;
            end
            if (pl === 1'b0 && pwm_l === 1'b1 && lq.size() > 0) begin
                e = lq.pop_front(); matched++;
                total++; if (cyc !== e) $display("FAIL dt_l_rise got cyc %0d want %0d", cyc, e); else passed++;
            end
            ph = pwm_h; pl = pwm_l;
        end
        total++; if (both !== 0) $display("FAIL dt_overlap got %0d want 0", both); else passed++;
        total++; if (matched < 4) $display("FAIL dt_edges got %0d want >=4", matched); else passed++;
        hq.delete(); lq.delete();
    endtask

    task automatic test_double_buffer();
        int h, bad_ready, e;
        bit found;
        enable = 1'b0;
        tick();
        configure(100, 0);
        enable = 1'b1;
        wait_sync(300, found);
        total++; if (found !== 1'b1) $display("FAIL db_sync got timeout want valley"); else passed++;
        for (int w = 0; w < 4; w++) begin
            h = 0; bad_ready = 0;
            for (int k = 1; k <= 200; k++) begin
                tick();
                if (pwm_h === 1'b1) h++;
                if (k == 1) duty_valid = 1'b0;
                if (w == 1 && k == 1) begin
                    total++; if (duty_ready !== 1'b1) $display("FAIL db_ready_return got %0b want 1", duty_ready); else passed++;
                end
                if (w == 2 && k == 1) begin
                    total++; if (duty_ready !== 1'b0) $display("FAIL db_valley_accept got %0b want 0", duty_ready); else passed++;
                end
                if (w == 0 && k == 31) duty_valid = 1'b0;
                if (w == 0 && k >= 31 && duty_ready !== 1'b0) bad_ready++;
                if (w == 0 && k == 30) begin
                    duty = 20; duty_valid = 1'b1;
                    exp_q.push_back(99); exp_q.push_back(119);
                end
            end
            total++; if (sync_valley !== 1'b1) $display("FAIL db_align[%0d] got %0b want 1", w, sync_valley); else passed++;
            e = exp_q.pop_front();
            total++; if (h !== e) $display("FAIL db_high[%0d] got %0d want %0d", w, h, e); else passed++;
            if (w == 0) begin
                total++; if (bad_ready !== 0) $display("FAIL db_ready_low got %0d bad want 0", bad_ready); else passed++;
            end
            if (w == 1) begin
                duty = -40; duty_valid = 1'b1;
                exp_q.push_back(119); exp_q.push_back(59);
            end
        end
    endtask

    task automatic test_fault();
        int h, e;
        bit found;
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (pwm_h === 1'b1) begin found = 1'b1; break; end
        end
        total++; if (found !== 1'b1) $display("FAIL flt_wait got timeout want pwm_h"); else passed++;
        fault = 1'b1;
        tick();
        fault = 1'b0;
        total++; if ({pwm_h, pwm_l} !== 2'b00) $display("FAIL flt_gates got %b want 00", {pwm_h, pwm_l}); else passed++;
        total++; if (state !== 2'd2) $display("FAIL flt_state got %0d want 2", state); else passed++;
        total++; if (carrier !== 32'sd0) $display("FAIL flt_carrier got %0d want 0", carrier); else passed++;
        repeat (3) tick();
        total++; if (state !== 2'd2) $display("FAIL flt_latch got %0d want 2", state); else passed++;
        enable = 1'b0;
        tick();
        total++; if (state !== 2'd0) $display("FAIL flt_idle got %0d want 0", state); else passed++;
        total++; if (cfg_ready !== 1'b1) $display("FAIL flt_cfg_ready got %0b want 1", cfg_ready); else passed++;
        enable = 1'b1;
        exp_q.push_back(99);
        wait_sync(300, found);
        total++; if (found !== 1'b1) $display("FAIL flt_resync got timeout want valley"); else passed++;
        h = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (pwm_h === 1'b1) h++;
        end
        e = exp_q.pop_front();
        total++; if (h !== e) $display("FAIL flt_duty_cleared got %0d want %0d", h, e); else passed++;
    endtask

    task automatic test_reset_mid();
        logic pl, ph;
        int t_l, lag, e;
        bit found;
        enable = 1'b0;
        tick();
        configure(100, 5);
        enable = 1'b1;
        pl = pwm_l; found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (pl === 1'b1 && pwm_l === 1'b0) begin found = 1'b1; break; end
            pl = pwm_l;
        end
        total++; if (found !== 1'b1) $display("FAIL rm_wait got timeout want pwm_l fall"); else passed++;
        #2 rst_n = 1'b0; enable = 1'b0;
        #1;
        total++; if ({pwm_h, pwm_l, sync_valley} !== 3'b000) $display("FAIL rm_gates got %b want 000", {pwm_h, pwm_l, sync_valley}); else passed++;
        total++; if (carrier !== 32'sd0 || state !== 2'd0) $display("FAIL rm_carrier_state got %0d/%0d want 0/0", carrier, state); else passed++;
        #3 rst_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        tick();
        total++; if (carrier !== -32'sd2500) $display("FAIL rm_default_p got %0d want -2500", carrier); else passed++;
        pl = pwm_l; ph = pwm_h; t_l = -1; lag = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (pl === 1'b1 && pwm_l === 1'b0) t_l = cyc;
            if (ph === 1'b0 && pwm_h === 1'b1 && t_l >= 0) begin lag = cyc - t_l; break; end
            pl = pwm_l; ph = pwm_h;
        end
        total++; if (lag !== 10) $display("FAIL rm_default_dt got %0d want 10", lag); else passed++;
        enable = 1'b0;
        tick();
        configure(1, 0);
        for (int k = 0; k < 8; k++) exp_q.push_back(model_carrier(k, 2));
        enable = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            e = exp_q.pop_front();
            total++; if (carrier !== e) $display("FAIL p_min[%0d] got %0d want %0d", k, carrier, e); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_carrier();
        test_duty_levels();
        test_deadtime();
        test_double_buffer();
        test_fault();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
